// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode, execute, memory and write-back.
// Outputs are decoded from the current state; memory states stall on MEM_READY, and exceptions redirect to vector 0.
module mips_multicycle_control #(
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNCT_WIDTH  = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [OPCODE_WIDTH-1:0] OPCODE,
  input  logic [FUNCT_WIDTH-1:0]  FUNCT,
  input  logic                    ZERO,
  input  logic                    OVERFLOW,
  input  logic                    MEM_READY,
  output logic                    PC_LOAD,
  output logic                    IorD,
  output logic                    IR_EN,
  output logic                    EPC_EN,
  output logic [2:0]              PC_SEL,
  output logic                    MEM_RD,
  output logic                    MEM_WR,
  output logic                    REG_WRITE,
  output logic                    REG_DST,
  output logic                    MEM_TO_REG,
  output logic                    ALU_SRC_A,
  output logic [1:0]              ALU_SRC_B,
  output logic [1:0]              ALU_OP,
  output logic                    CAUSE_EN,
  output logic                    CAUSE,
  output logic [3:0]              STATE
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JR        = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_EXCEPTION = 4'd13
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = OPCODE_WIDTH'(6'b000101);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
  localparam logic [FUNCT_WIDTH-1:0]  FN_JR    = FUNCT_WIDTH'(6'b001000);
  localparam logic [FUNCT_WIDTH-1:0]  FN_ADD   = FUNCT_WIDTH'(6'b100000);
  localparam logic [FUNCT_WIDTH-1:0]  FN_SUB   = FUNCT_WIDTH'(6'b100010);

  state_e state_q, state_d;
  logic   cause_q, cause_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    cause_d    = cause_q;
    PC_LOAD    = 1'b0;
    IorD       = 1'b0;
    IR_EN      = 1'b0;
    EPC_EN     = 1'b0;
    PC_SEL     = 3'd0;
    MEM_RD     = 1'b0;
    MEM_WR     = 1'b0;
    REG_WRITE  = 1'b0;
    REG_DST    = 1'b0;
    MEM_TO_REG = 1'b0;
    ALU_SRC_A  = 1'b0;
    ALU_SRC_B  = 2'd0;
    ALU_OP     = 2'b00;
    CAUSE_EN   = 1'b0;
    CAUSE      = 1'b0;

    case (state_q)
      S_FETCH: begin
        MEM_RD    = 1'b1;
        ALU_SRC_B = 2'd1;
        IR_EN     = MEM_READY;
        PC_LOAD   = MEM_READY;
        state_d   = MEM_READY ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALU_SRC_B = 2'd3;
        if (OPCODE == OP_RTYPE)
          state_d = (FUNCT == FN_JR) ? S_JR : S_EXECUTE;
        else if (OPCODE == OP_LW || OPCODE == OP_SW)
          state_d = S_MEM_ADDR;
        else if (OPCODE == OP_BEQ || OPCODE == OP_BNE)
          state_d = S_BRANCH;
        else if (OPCODE == OP_J)
          state_d = S_JUMP;
        else if (OPCODE == OP_ADDI)
          state_d = S_ADDI_EXEC;
        else begin
          state_d = S_EXCEPTION;
          cause_d = 1'b0;
        end
      end
      S_MEM_ADDR: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = 2'd2;
        if (OPCODE == OP_LW)      state_d = S_MEM_READ;
        else if (OPCODE == OP_SW) state_d = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MEM_RD  = 1'b1;
        IorD    = 1'b1;
        state_d = MEM_READY ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        REG_WRITE  = 1'b1;
        MEM_TO_REG = 1'b1;
      end
      S_MEM_WRITE: begin
        MEM_WR  = 1'b1;
        IorD    = 1'b1;
        state_d = MEM_READY ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        ALU_SRC_A = 1'b1;
        ALU_OP    = 2'b10;
        // Only the trapping forms add/sub raise overflow; addu/subu wrap silently.
        if (OVERFLOW && (FUNCT == FN_ADD || FUNCT == FN_SUB)) begin
          state_d = S_EXCEPTION;
          cause_d = 1'b1;
        end else begin
          state_d = S_ALU_WB;
        end
      end
      S_ALU_WB: begin
        REG_WRITE = 1'b1;
        REG_DST   = 1'b1;
      end
      S_BRANCH: begin
        ALU_SRC_A = 1'b1;
        ALU_OP    = 2'b01;
        PC_SEL    = 3'd1;
        PC_LOAD   = (OPCODE == OP_BNE) ? ~ZERO : ZERO;
      end
      S_JUMP: begin
        PC_SEL  = 3'd2;
        PC_LOAD = 1'b1;
      end
      S_JR: begin
        PC_SEL  = 3'd3;
        PC_LOAD = 1'b1;
      end
      S_ADDI_EXEC: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = 2'd2;
        if (OVERFLOW) begin
          state_d = S_EXCEPTION;
          cause_d = 1'b1;
        end else begin
          state_d = S_ADDI_WB;
        end
      end
      S_ADDI_WB: begin
        REG_WRITE = 1'b1;
      end
      S_EXCEPTION: begin
        EPC_EN   = 1'b1;
        CAUSE_EN = 1'b1;
        CAUSE    = cause_q;
        PC_SEL   = 3'd4;
        PC_LOAD  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every enable immediately, before the state register settles.
    if (RST) begin
      PC_LOAD   = 1'b0;
      IR_EN     = 1'b0;
      EPC_EN    = 1'b0;
      MEM_RD    = 1'b0;
      MEM_WR    = 1'b0;
      REG_WRITE = 1'b0;
      CAUSE_EN  = 1'b0;
    end
  end

  assign STATE = state_q;

endmodule
